// File: rtl/mult_div_pkg.sv
// Shared MDU definitions: ALU funct codes for HI/LO ops, FSM state type,
// and divider width / iteration count.
package mult_div_pkg;

  localparam int unsigned FUNCT_W = 6;

  localparam logic [FUNCT_W-1:0] FUNCT_MFHI  = 6'b010000;
  localparam logic [FUNCT_W-1:0] FUNCT_MTHI  = 6'b010001;
  localparam logic [FUNCT_W-1:0] FUNCT_MFLO  = 6'b010010;
  localparam logic [FUNCT_W-1:0] FUNCT_MTLO  = 6'b010011;
  localparam logic [FUNCT_W-1:0] FUNCT_MULT  = 6'b011000;
  localparam logic [FUNCT_W-1:0] FUNCT_MULTU = 6'b011001;
  localparam logic [FUNCT_W-1:0] FUNCT_DIV   = 6'b011010;
  localparam logic [FUNCT_W-1:0] FUNCT_DIVU  = 6'b011011;

  localparam int unsigned DIV_W     = 32;
  localparam int unsigned DIV_ITERS = 32;
  localparam int unsigned CNT_W     = $clog2(DIV_ITERS);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(DIV_ITERS - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DIV_RUN,
    ST_DONE
  } mdu_state_e;

  function automatic logic is_div(input logic [FUNCT_W-1:0] f);
    return (f == FUNCT_DIV) || (f == FUNCT_DIVU);
  endfunction

endpackage

// File: rtl/mult_div_div_core.sv
// Iterative restoring divider: one quotient bit per cycle on operand
// magnitudes, sign fix-up and divide-by-zero values applied on the way out.
// Holds only its own working registers; HI/LO live in the parent.
module div_core
  import mult_div_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             abort,
  input  logic             start,
  input  logic             signed_op,
  input  logic [DIV_W-1:0] a,
  input  logic [DIV_W-1:0] b,
  output logic             done,
  output logic [DIV_W-1:0] quot,
  output logic [DIV_W-1:0] rem
);

  logic             r_run;
  logic [CNT_W-1:0] r_cnt;
  logic [DIV_W-1:0] r_rem;
  logic [DIV_W-1:0] r_quo;
  logic [DIV_W-1:0] r_div;
  logic [DIV_W-1:0] r_a;
  logic             r_neg_q;
  logic             r_neg_r;
  logic             r_zero;

  logic [DIV_W-1:0] w_a_mag;
  logic [DIV_W-1:0] w_b_mag;
  logic [DIV_W:0]   w_shift;
  logic             w_ge;
  logic [DIV_W-1:0] w_rem_nx;
  logic [DIV_W-1:0] w_quo_nx;

  assign w_a_mag = (signed_op && a[DIV_W-1]) ? -a : a;
  assign w_b_mag = (signed_op && b[DIV_W-1]) ? -b : b;

  // One restoring step: shift next dividend bit into the partial remainder
  // and subtract the divisor when it fits.
  always_comb begin
    w_shift  = {r_rem, r_quo[DIV_W-1]};
    w_ge     = (w_shift >= {1'b0, r_div});
    w_rem_nx = w_ge ? DIV_W'(w_shift - {1'b0, r_div}) : DIV_W'(w_shift);
    w_quo_nx = {r_quo[DIV_W-2:0], w_ge};
  end

  assign done = r_run && (r_cnt == LAST_ITER);

  // Final values are taken from the last step's next-state so the parent can
  // write HI/LO on the same edge that retires the last iteration.
  always_comb begin
    if (r_zero) begin
      quot = '1;
      rem  = r_a;
    end else begin
      quot = r_neg_q ? -w_quo_nx : w_quo_nx;
      rem  = r_neg_r ? -w_rem_nx : w_rem_nx;
    end
  end

  // Operand latch on start, then iterate until the last quotient bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_run   <= 1'b0;
      r_cnt   <= '0;
      r_rem   <= '0;
      r_quo   <= '0;
      r_div   <= '0;
      r_a     <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_zero  <= 1'b0;
    end else if (abort) begin
      r_run <= 1'b0;
      r_cnt <= '0;
    end else if (start) begin
      r_run   <= 1'b1;
      r_cnt   <= '0;
      r_rem   <= '0;
      r_quo   <= w_a_mag;
      r_div   <= w_b_mag;
      r_a     <= a;
      r_neg_q <= signed_op && (a[DIV_W-1] ^ b[DIV_W-1]);
      r_neg_r <= signed_op && a[DIV_W-1];
      r_zero  <= (b == '0);
    end else if (r_run) begin
      r_rem <= w_rem_nx;
      r_quo <= w_quo_nx;
      r_cnt <= r_cnt + 1'b1;
      if (r_cnt == LAST_ITER) begin
        r_run <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/mult_div.sv
// HI/LO multiply-divide unit: single-cycle MULT/MULTU/MTHI/MTLO, combinational
// MFHI/MFLO read, multi-cycle DIV/DIVU through div_core with pipeline stall.
// Optional build macro MDU_DIV_ZERO_FAST_EN: divide-by-zero completes in the
// accept cycle without stalling.
module mult_div
  import mult_div_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [FUNCT_W-1:0] funct,
  input  logic [31:0]        operand_1,
  input  logic [31:0]        operand_2,
  input  logic               flush,
  output logic               busy,
  output logic [31:0]        result,
  output logic [31:0]        hi,
  output logic [31:0]        lo
);

  mdu_state_e  r_state;
  logic [31:0] r_hi;
  logic [31:0] r_lo;

  logic        w_idle;
  logic        w_div_req;
  logic        w_fast_zero;
  logic        w_start;
  logic        w_div_done;
  logic [31:0] w_quot;
  logic [31:0] w_rem;
  logic [63:0] w_prod_s;
  logic [63:0] w_prod_u;

  assign w_idle    = (r_state == ST_IDLE);
  assign w_div_req = w_idle && en && is_div(funct);

`ifdef MDU_DIV_ZERO_FAST_EN
  assign w_fast_zero = w_div_req && (operand_2 == '0);
`else
  assign w_fast_zero = 1'b0;
`endif

  assign w_start = w_div_req && !w_fast_zero && !flush;
  assign busy    = (w_div_req && !w_fast_zero) || (r_state == ST_DIV_RUN);

  assign w_prod_s = $signed({{32{operand_1[31]}}, operand_1}) *
                    $signed({{32{operand_2[31]}}, operand_2});
  assign w_prod_u = {32'b0, operand_1} * {32'b0, operand_2};

  assign hi = r_hi;
  assign lo = r_lo;

  div_core u_div_core (
    .clk       (clk),
    .rst       (rst),
    .abort     (flush),
    .start     (w_start),
    .signed_op (funct == FUNCT_DIV),
    .a         (operand_1),
    .b         (operand_2),
    .done      (w_div_done),
    .quot      (w_quot),
    .rem       (w_rem)
  );

  // MFHI/MFLO read path; only an accepting (idle) unit answers.
  always_comb begin
    result = '0;
    if (w_idle && en) begin
      if (funct == FUNCT_MFHI) begin
        result = r_hi;
      end else if (funct == FUNCT_MFLO) begin
        result = r_lo;
      end
    end
  end

  // Control FSM and HI/LO writes; flush cancels everything in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_hi    <= '0;
      r_lo    <= '0;
    end else if (flush) begin
      r_state <= ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (en) begin
            case (funct)
              FUNCT_MTHI:  r_hi <= operand_1;
              FUNCT_MTLO:  r_lo <= operand_1;
              FUNCT_MULT:  {r_hi, r_lo} <= w_prod_s;
              FUNCT_MULTU: {r_hi, r_lo} <= w_prod_u;
              FUNCT_DIV, FUNCT_DIVU: begin
                if (w_fast_zero) begin
                  r_hi    <= operand_1;
                  r_lo    <= '1;
                  r_state <= ST_DONE;
                end else begin
                  r_state <= ST_DIV_RUN;
                end
              end
              default: ;
            endcase
          end
        end
        ST_DIV_RUN: begin
          if (w_div_done) begin
            r_hi    <= w_rem;
            r_lo    <= w_quot;
            r_state <= ST_DONE;
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/mult_div.md
MULT_DIV -- requirements
Module: mult_div

Interface
REQ-001 SHALL have ports: clk  in  1  rising-edge clock for all state.
REQ-002 SHALL have ports: rst  in  1  asynchronous reset, active-high.
REQ-003 SHALL have ports: en  in  1  EX holds a valid SPECIAL-op instruction.
REQ-004 SHALL have ports: funct  in  `FUNCT_BUS  ALU function code from ID.
REQ-005 SHALL have ports: operand_1 / operand_2  in  32 each  rs / rt values.
REQ-006 SHALL have ports: flush  in  1  pipeline flush (exception or ERET).
REQ-007 SHALL have ports: busy  out  1  stall request to pipeline control.
REQ-008 SHALL have ports: result  out  32  MFHI/MFLO read data.
REQ-009 SHALL have ports: hi / lo  out  32 each  architectural HI/LO registers.

Function
REQ-010 Decoded functs SHALL be MFHI, MTHI, MFLO, MTLO, MULT, MULTU, DIV, DIVU. All other codes, and en=0, SHALL have no effect, with result=0.
REQ-011 MULT/MULTU (signed/unsigned 32x32->64) SHALL write HI=product[63:32] and LO=product[31:0] at the edge ending the accept cycle T; busy SHALL stay 0.
REQ-012 MTHI/MTLO SHALL write operand_1 into HI/LO at the edge ending T.
REQ-013 result SHALL be combinational: MFHI->hi, MFLO->lo. A MF* in cycle T+1 SHALL see the T write.
REQ-014 FSM states SHALL be IDLE, DIV_RUN, DONE. Only IDLE SHALL accept instructions.
REQ-015 DIV/DIVU with en in IDLE at cycle T SHALL: latch operands; go to DIV_RUN; set counter=0.
REQ-016 DIV_RUN SHALL produce one restoring-division quotient bit per cycle. After 32 iterations it SHALL write HI=remainder and LO=quotient, then enter DONE.
REQ-017 busy SHALL equal (IDLE & en & funct in {DIV,DIVU}) | DIV_RUN. It SHALL be high in cycles T..T+32 and low in DONE (T+33).
REQ-018 DONE SHALL last one cycle, ignore en (the stalled DIV leaves EX), and return to IDLE.
REQ-019 Signed DIV SHALL divide magnitudes. The quotient SHALL be negated when operand signs differ; the remainder SHALL take the dividend's sign. 0x80000000/-1 SHALL give LO=0x80000000, HI=0.
REQ-020 Divisor zero SHALL give HI=operand_1 and LO=0xFFFFFFFF for both signed and unsigned division.
REQ-021 While not IDLE, en/funct/operands SHALL be ignored; only the latched operands SHALL be used.
REQ-022 flush SHALL have priority over every other action. In any state it SHALL force IDLE at the next edge, with HI/LO unchanged and no pending write. flush in cycle T SHALL also suppress that cycle's MULT/MT*/DIV accept.

Reset
REQ-023 rst SHALL asynchronously set: state=IDLE, counter=0, hi=0, lo=0, and latched operands=0. busy and result SHALL then read 0.
REQ-024 rst mid-division SHALL abandon the operation with no HI/LO write. The first edge after release SHALL accept normally.

Configuration
REQ-025 Macro MDU_DIV_ZERO_FAST_EN, when defined, SHALL make divide-by-zero skip DIV_RUN. That case SHALL go IDLE->DONE, write REQ-020 values at the edge ending T, and keep busy=0.
REQ-026 Without MDU_DIV_ZERO_FAST_EN, divide-by-zero SHALL take the full 32-cycle path (REQ-017 timing) and then write the REQ-020 values.

Structure
REQ-027 FUNCT_MFHI..FUNCT_DIVU SHALL stay in funct.v. The state encodings and the divider width/iteration count SHALL go in a new shared header mdu.v.
REQ-028 Division SHALL be a sub-module div_core with ports start, signed_op, a, b, done, quot, rem. It SHALL contain no HI/LO storage.

Verification
REQ-029 Bench SHALL check: MULT 0xFFFFFFFF x 2 -> HI=0xFFFFFFFF, LO=0xFFFFFFFE at T+1, busy=0. MULTU with the same operands -> HI=0x00000001, LO=0xFFFFFFFE.
REQ-030 Bench SHALL check: DIV -7/2 held with en -> busy high 33 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 100/7 -> LO=14, HI=2.
REQ-031 Bench SHALL check: DIV 5/0 -> HI=5, LO=0xFFFFFFFF. busy high 33 cycles without the macro, 0 cycles with it.
REQ-032 Bench SHALL check: flush at iteration 10 of DIVU 100/7 with HI=LO=0x1234 beforehand -> busy low next cycle, HI/LO still 0x1234. A subsequent DIVU then completes correctly.
REQ-033 Bench SHALL check: MTHI 0xA5A5A5A5, then MFHI next cycle -> result=0xA5A5A5A5. DIV 0x80000000/-1 -> LO=0x80000000, HI=0.
REQ-034 Bench SHALL check: rst asserted mid-DIV_RUN -> hi=lo=0 and busy=0 immediately, without waiting for a clock edge.
